serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 c  input  1  carry-in.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 s_out  output  WIDTH  sum result.
REQ-012 c_out  output  1  carry-out result.

Function
REQ-013 Computes {c_out, s_out} = a + b + c, one bit per clock through a single 1-bit full-adder cell, LSB first.
REQ-014 FSM states: IDLE, BUSY, DONE; no other states reachable.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, capture a, b, c, clear bit counter, go BUSY.
REQ-016 BUSY: each cycle, add bit[cnt] of captured A and B with registered carry, write sum bit to s_out[cnt], update carry, increment cnt.
REQ-017 BUSY lasts exactly WIDTH cycles; on the edge processing bit WIDTH-1, go DONE with c_out = final carry.
REQ-018 Latency: handshake at edge k -> out_valid=1 after edge k+WIDTH.
REQ-019 DONE: out_valid=1, in_ready=0; s_out/c_out held stable while out_valid=1 and out_ready=0.
REQ-020 DONE with out_ready=1 at an edge -> IDLE; out_valid=0 after that edge; s_out/c_out retain last value.
REQ-021 in_ready=0 in BUSY and DONE; in_valid and a/b/c ignored there; captured operands unaffected.
REQ-022 Input changes after capture do not affect the result.
REQ-023 Carry wraps out only via c_out; s_out is the sum modulo 2^WIDTH.
REQ-024 WIDTH=1: BUSY lasts one cycle; same handshake rules.
REQ-025 in_ready and out_valid are decoded from registered state only; no combinational path from in_valid or out_ready to any output.

Reset
REQ-026 rst_n low, at any time including mid-BUSY or DONE: state=IDLE, counter=0, carry=0, captured operands=0.
REQ-027 Output values during and after reset: in_ready=1, out_valid=0, s_out=0, c_out=0.
REQ-028 An in-flight operation interrupted by reset is discarded; no partial result is presented.
REQ-029 Reset deassertion is synchronised by the integrator; the block requires no extra idle cycles after it.

Structure
REQ-030 Package serial_adder_pkg holds the state enum (IDLE, BUSY, DONE) and the WIDTH default constant.
REQ-031 Sub-module fa_cell is a combinational 1-bit full adder (inputs x, y, ci; outputs s, co), instantiated once.
REQ-032 Counter width is $clog2(WIDTH+1); no other arithmetic outside fa_cell.

Verification
REQ-033 a=8'hFF, b=8'h01, c=0, out_ready=1 -> out_valid 8 cycles after handshake, s_out=8'h00, c_out=1.
REQ-034 a=8'h5A, b=8'hA5, c=1 -> s_out=8'h00, c_out=1; in_ready=0 throughout BUSY and DONE.
REQ-035 a=8'h12, b=8'h34, c=0, out_ready=0 for 5 cycles after out_valid -> s_out=8'h46, c_out=0 held stable, then IDLE on the cycle after out_ready=1.
REQ-036 Second operand set (8'hFF, 8'hFF) driven with in_valid=1 during BUSY -> ignored; first result unchanged; accepted only once back in IDLE.
REQ-037 rst_n pulsed low at bit 4 of BUSY -> out_valid=0, in_ready=1, s_out=0 immediately; next operation a=8'h03, b=8'h04 -> s_out=8'h07.
REQ-038 WIDTH=1, a=1, b=1, c=1 -> out_valid one cycle after handshake, s_out=1, c_out=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default operand width
package serial_adder_pkg;
    localparam int WIDTH_DEFAULT = 8;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: combinational 1-bit full adder, the only arithmetic of the serial adder
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial {c_out, s_out} = a + b + c, LSB first, valid/ready on both sides
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s_out,
    output logic             c_out
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sel;
    logic             carry;
    logic             sum_bit;
    logic             carry_nxt;

    // one-hot select of the bit currently being processed
    assign sel       = WIDTH'(1) << cnt;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    fa_cell u_fa (
        .x  (|(a_q & sel)),
        .y  (|(b_q & sel)),
        .ci (carry),
        .s  (sum_bit),
        .co (carry_nxt)
    );

    // capture operands, walk one bit per cycle, hold the result until it is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            s_out <= '0;
            c_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q   <= a;
                    b_q   <= b;
                    carry <= c;
                    cnt   <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    s_out <= sum_bit ? (s_out | sel) : (s_out & ~sel);
                    carry <= carry_nxt;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        c_out <= carry_nxt;
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random and directed checks of serial_adder against an arithmetic model
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         c = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, c_out;
    logic [W-1:0] s_out;

    logic in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic in_ready1, out_valid1, c_out1;
    logic s_out1;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
        .s_out(s_out), .c_out(c_out)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .c(c1), .out_valid(out_valid1), .out_ready(out_ready1),
        .s_out(s_out1), .c_out(c_out1)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // transaction-level model: accepted sum, cycles left until presented, last presented result
    logic       m_pending = 1'b0;
    logic       m_done = 1'b0;
    int         m_left = 0;
    logic [W:0] m_res = '0;
    logic [W:0] m_shown = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending <= 1'b0;
            m_done    <= 1'b0;
            m_left    <= 0;
            m_res     <= '0;
            m_shown   <= '0;
        end else if (m_done) begin
            if (out_ready) m_done <= 1'b0;
        end else if (m_pending) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_pending <= 1'b0;
                m_done    <= 1'b1;
                m_shown   <= m_res;
            end
        end else if (in_valid) begin
            m_pending <= 1'b1;
            m_left    <= W;
            m_res     <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        end
    end

    always @(negedge clk) begin
        check("in_ready", in_ready, !m_pending && !m_done);
        check("out_valid", out_valid, m_done);
        if (!m_pending) begin
            check("s_out", s_out, m_shown[W-1:0]);
            check("c_out", c_out, m_shown[W]);
        end
    end

    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input logic early_ordy, input int hold, input logic spam,
                      input logic [W:0] exp, input string nm);
        int n;
        check({nm, "_idle_ready"}, in_ready, 1);
        a = ta; b = tb; c = tc; in_valid = 1'b1; out_ready = early_ordy;
        @(posedge clk); #1;
        in_valid = spam;
        a = spam ? '1 : W'($urandom);
        b = spam ? '1 : W'($urandom);
        c = spam ? 1'b0 : 1'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin
            check({nm, "_busy_ready"}, in_ready, 0);
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_latency"}, n, W);
        check({nm, "_sum"}, s_out, exp[W-1:0]);
        check({nm, "_carry"}, c_out, exp[W]);
        check({nm, "_done_ready"}, in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({nm, "_hold_valid"}, out_valid, 1);
            check({nm, "_hold_sum"}, s_out, exp[W-1:0]);
            check({nm, "_hold_carry"}, c_out, exp[W]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, "_ret_valid"}, out_valid, 0);
        check({nm, "_ret_ready"}, in_ready, 1);
        check({nm, "_ret_sum"}, s_out, exp[W-1:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int e1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_s_out", s_out, 0);
        check("rst_c_out", c_out, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op(8'hFF, 8'h01, 1'b0, 1'b1, 0, 1'b0, 9'h100, "ff_01");
        op(8'h5A, 8'hA5, 1'b1, 1'b1, 0, 1'b0, 9'h100, "5a_a5");
        op(8'h12, 8'h34, 1'b0, 1'b0, 5, 1'b0, 9'h046, "12_34_hold");
        op(8'h55, 8'h22, 1'b0, 1'b0, 2, 1'b1, 9'h077, "busy_spam");
        op(8'hFF, 8'hFF, 1'b0, 1'b1, 0, 1'b0, 9'h1FE, "ff_ff");

        a = 8'h77; b = 8'h11; c = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_partial_nonzero", s_out != 0, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_s_out", s_out, 0);
        check("mid_rst_c_out", c_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        op(8'h03, 8'h04, 1'b0, 1'b1, 0, 1'b0, 9'h007, "after_rst");

        for (int i = 0; i < 800; i++) begin
            in_valid  = 1'($urandom);
            a         = W'($urandom);
            b         = W'($urandom);
            c         = 1'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (W + 3) @(posedge clk);
        #1;
        out_ready = 1'b0;

        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = 3'(i);
            e1 = int'(a1) + int'(b1) + int'(c1);
            in_valid1 = 1'b1;
            check("w1_ready", in_ready1, 1);
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            check("w1_busy_valid", out_valid1, 0);
            check("w1_busy_ready", in_ready1, 0);
            @(posedge clk); #1;
            check("w1_valid", out_valid1, 1);
            check("w1_sum", s_out1, e1 & 1);
            check("w1_carry", c_out1, e1 >> 1);
            if (i == 7) begin
                check("w1_111_sum", s_out1, 1);
                check("w1_111_carry", c_out1, 1);
            end
            out_ready1 = 1'b1;
            @(posedge clk); #1;
            out_ready1 = 1'b0;
            check("w1_ret_valid", out_valid1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
